// File: rtl/rom_load_ctrl_if.sv
// rtl/rom_load_ctrl_if.sv - download stream in, ROM write port out
interface rom_load_ctrl_if #(
  parameter int unsigned AW = 17
);
  logic          ioctl_download;
  logic          ioctl_wr;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_dout;
  logic [3:0]    rom_we;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
    input  rom_we, rom_addr, rom_data
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
    output rom_we, rom_addr, rom_data
  );
endinterface

// File: rtl/rom_load_ctrl.sv
// rtl/rom_load_ctrl.sv - ROM download sequencer: region decode, size/checksum check, core reset owner
module rom_load_ctrl #(
  parameter int unsigned AW          = 17,
  parameter logic [24:0] R1_BASE     = 25'h08000,
  parameter logic [24:0] R2_BASE     = 25'h10000,
  parameter logic [24:0] R3_BASE     = 25'h18000,
  parameter logic [24:0] IMG_SIZE    = 25'h1C000,
  parameter logic [15:0] HOLD_CYCLES = 16'd4096
) (
  input  logic           clk_sys,
  input  logic           reset_n,
  rom_load_ctrl_if.slave bus,
  output logic           core_reset,
  output logic           load_ok,
  output logic           load_err,
  output logic [24:0]    byte_cnt,
  output logic [7:0]     csum
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_HOLD = 3'd2,
    S_RUN  = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    rom_we_q, rom_we_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic [7:0]    rom_data_q, rom_data_d;
  logic          core_reset_q, core_reset_d;
  logic          load_ok_q, load_ok_d;
  logic          load_err_q, load_err_d;
  logic [24:0]   byte_cnt_q, byte_cnt_d;
  logic [7:0]    csum_q, csum_d;
  logic          oor_q, oor_d;
  logic [15:0]   hold_q, hold_d;

  logic [1:0]    region;
  logic [24:0]   region_base;
  logic [24:0]   region_off;
  logic          in_range;
  logic          wr_acc;
  logic          size_ok;

  assign wr_acc  = (state_q == S_LOAD) && bus.ioctl_download && bus.ioctl_wr;
  assign size_ok = (byte_cnt_q == IMG_SIZE) && !oor_q;

  // Flat address to region index and base; anything at or past IMG_SIZE is out of range.
  always_comb begin
    region      = 2'd0;
    region_base = 25'd0;
    in_range    = 1'b1;
    if (bus.ioctl_addr < R1_BASE) begin
      region      = 2'd0;
      region_base = 25'd0;
    end else if (bus.ioctl_addr < R2_BASE) begin
      region      = 2'd1;
      region_base = R1_BASE;
    end else if (bus.ioctl_addr < R3_BASE) begin
      region      = 2'd2;
      region_base = R2_BASE;
    end else if (bus.ioctl_addr < IMG_SIZE) begin
      region      = 2'd3;
      region_base = R3_BASE;
    end else begin
      in_range    = 1'b0;
    end
  end

  assign region_off = bus.ioctl_addr - region_base;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_LOAD: begin
        if (!bus.ioctl_download) begin
          state_d = size_ok ? S_HOLD : S_ERR;
        end
      end
      S_HOLD: begin
        if (bus.ioctl_download) begin
          state_d = S_LOAD;
        end else if (hold_q == 16'd0) begin
          state_d = S_RUN;
        end
      end
      S_IDLE, S_RUN, S_ERR: begin
        if (bus.ioctl_download) begin
          state_d = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rom_we_d     = 4'b0000;
    rom_addr_d   = rom_addr_q;
    rom_data_d   = rom_data_q;
    core_reset_d = core_reset_q;
    load_ok_d    = load_ok_q;
    load_err_d   = load_err_q;
    byte_cnt_d   = byte_cnt_q;
    csum_d       = csum_q;
    oor_d        = oor_q;
    hold_d       = hold_q;

    if ((state_q != S_LOAD) && (state_d == S_LOAD)) begin
      byte_cnt_d   = 25'd0;
      csum_d       = 8'd0;
      load_ok_d    = 1'b0;
      load_err_d   = 1'b0;
      oor_d        = 1'b0;
      core_reset_d = 1'b1;
    end

    if (wr_acc) begin
      if (in_range) begin
        rom_we_d   = 4'b0001 << region;
        rom_addr_d = region_off[AW-1:0];
        rom_data_d = bus.ioctl_dout;
        byte_cnt_d = (byte_cnt_q == '1) ? byte_cnt_q : byte_cnt_q + 25'd1;
        csum_d     = csum_q + bus.ioctl_dout;
      end else begin
        oor_d      = 1'b1;
      end
    end

    if ((state_q == S_LOAD) && (state_d == S_HOLD)) begin
      load_ok_d = 1'b1;
      hold_d    = HOLD_CYCLES - 16'd1;
    end
    if ((state_q == S_LOAD) && (state_d == S_ERR)) begin
      load_err_d = 1'b1;
    end
    if ((state_q == S_HOLD) && (state_d == S_HOLD)) begin
      hold_d = hold_q - 16'd1;
    end
    if (state_d == S_RUN) begin
      core_reset_d = 1'b0;
    end
  end

  // Async clear also cancels an in-flight rom_we pulse the moment reset_n drops.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rom_we_q     <= 4'b0000;
      rom_addr_q   <= '0;
      rom_data_q   <= 8'd0;
      core_reset_q <= 1'b1;
      load_ok_q    <= 1'b0;
      load_err_q   <= 1'b0;
      byte_cnt_q   <= 25'd0;
      csum_q       <= 8'd0;
      oor_q        <= 1'b0;
      hold_q       <= 16'd0;
    end else begin
      rom_we_q     <= rom_we_d;
      rom_addr_q   <= rom_addr_d;
      rom_data_q   <= rom_data_d;
      core_reset_q <= core_reset_d;
      load_ok_q    <= load_ok_d;
      load_err_q   <= load_err_d;
      byte_cnt_q   <= byte_cnt_d;
      csum_q       <= csum_d;
      oor_q        <= oor_d;
      hold_q       <= hold_d;
    end
  end

  assign bus.rom_we   = rom_we_q;
  assign bus.rom_addr = rom_addr_q;
  assign bus.rom_data = rom_data_q;
  assign core_reset   = core_reset_q;
  assign load_ok      = load_ok_q;
  assign load_err     = load_err_q;
  assign byte_cnt     = byte_cnt_q;
  assign csum         = csum_q;

endmodule

// File: tb/tb_rom_load_ctrl.sv
// tb/tb_rom_load_ctrl.sv - randomized bench for rom_load_ctrl against a behavioural load model
module tb_rom_load_ctrl;
  localparam int unsigned AW   = 17;
  localparam logic [24:0] R1   = 25'h100;
  localparam logic [24:0] R2   = 25'h200;
  localparam logic [24:0] R3   = 25'h300;
  localparam logic [24:0] IMG  = 25'h400;
  localparam int          HOLD = 20;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        core_reset, load_ok, load_err;
  logic [24:0] byte_cnt;
  logic [7:0]  csum;

  rom_load_ctrl_if #(.AW(AW)) bus ();

  rom_load_ctrl #(
    .AW(AW), .R1_BASE(R1), .R2_BASE(R2), .R3_BASE(R3),
    .IMG_SIZE(IMG), .HOLD_CYCLES(16'(HOLD))
  ) dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .bus(bus),
    .core_reset(core_reset),
    .load_ok(load_ok),
    .load_err(load_err),
    .byte_cnt(byte_cnt),
    .csum(csum)
  );

  always #5 clk_sys = ~clk_sys;

  int total = 0;
  int bad   = 0;
  bit cur_dl = 1'b0;

  int bases [4] = '{0, int'(R1), int'(R2), int'(R3)};

  // Model of what a load means, not of how the controller sequences it.
  bit            m_loading;
  int            m_cnt, m_sum, m_rel;
  bit            m_oor, m_ok, m_err, m_cr;
  logic [3:0]    m_we;
  logic [AW-1:0] m_addr;
  logic [7:0]    m_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_loading = 0; m_cnt = 0; m_sum = 0; m_rel = -1;
    m_oor = 0; m_ok = 0; m_err = 0; m_cr = 1;
    m_we = '0; m_addr = '0; m_data = '0;
  endtask

  task automatic model_step(input bit dl, input bit wr, input logic [24:0] a, input logic [7:0] d);
    m_we = '0;
    if (m_loading) begin
      if (dl && wr) begin
        if (int'(a) < int'(IMG)) begin
          int r = 0;
          for (int i = 1; i < 4; i++) if (int'(a) >= bases[i]) r = i;
          m_we   = 4'(1 << r);
          m_addr = AW'(int'(a) - bases[r]);
          m_data = d;
          if (m_cnt < (1 << 25) - 1) m_cnt++;
          m_sum = (m_sum + int'(d)) % 256;
        end else begin
          m_oor = 1;
        end
      end
      if (!dl) begin
        m_loading = 0;
        if (m_cnt == int'(IMG) && !m_oor) begin
          m_ok  = 1;
          m_rel = HOLD;
        end else begin
          m_err = 1;
        end
      end
    end else if (dl) begin
      m_loading = 1; m_cnt = 0; m_sum = 0; m_oor = 0;
      m_ok = 0; m_err = 0; m_cr = 1; m_rel = -1;
    end else if (m_rel > 0) begin
      m_rel--;
      if (m_rel == 0) m_cr = 0;
    end
  endtask

  always @(negedge clk_sys) begin
    if (reset_n) begin
      check("rom_we", bus.rom_we, m_we);
      if (m_we != 4'b0000) begin
        check("rom_addr", bus.rom_addr, m_addr);
        check("rom_data", bus.rom_data, m_data);
      end
      check("core_reset", core_reset, m_cr);
      check("load_ok", load_ok, m_ok);
      check("load_err", load_err, m_err);
      check("byte_cnt", byte_cnt, m_cnt);
      check("csum", csum, m_sum);
    end
  end

  task automatic tick(input bit dl, input bit wr, input logic [24:0] a, input logic [7:0] d);
    bus.ioctl_download = dl;
    bus.ioctl_wr       = wr;
    bus.ioctl_addr     = a;
    bus.ioctl_dout     = d;
    @(posedge clk_sys);
    model_step(dl, wr, a, d);
    @(negedge clk_sys);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(cur_dl, cur_dl ? 1'b0 : 1'($urandom % 2),
                    25'($urandom % (int'(IMG) + 8)), 8'($urandom));
  endtask

  task automatic write_byte(input logic [24:0] a, input logic [7:0] d, input int gap);
    tick(1'b1, 1'b1, a, d);
    idle(gap);
  endtask

  task automatic start_dl();
    cur_dl = 1'b1;
    tick(1'b1, 1'($urandom % 2), 25'($urandom % int'(IMG)), 8'($urandom));
  endtask

  task automatic end_dl();
    cur_dl = 1'b0;
    tick(1'b0, 1'($urandom % 2), 25'($urandom % int'(IMG)), 8'($urandom));
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    cur_dl  = 1'b0;
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    model_reset();
    repeat (2) @(posedge clk_sys);
    @(negedge clk_sys);
    #1 reset_n = 1'b1;
  endtask

  task automatic seq_load(input int n, input int max_gap, input bit addr_data);
    for (int a = 0; a < n; a++)
      write_byte(25'(a), addr_data ? 8'(a) : 8'($urandom), $urandom_range(0, max_gap));
  endtask

  initial begin
    int n;
    int mode;
    int cnt;

    apply_reset();
    reset_n = 1'b0;
    #1;
    check("rst_core_reset", core_reset, 1);
    check("rst_rom_we", bus.rom_we, 0);
    check("rst_rom_addr", bus.rom_addr, 0);
    check("rst_rom_data", bus.rom_data, 0);
    check("rst_load_ok", load_ok, 0);
    check("rst_load_err", load_err, 0);
    check("rst_byte_cnt", byte_cnt, 0);
    check("rst_csum", csum, 0);
    apply_reset();
    idle(3);

    // Full load, data = addr[7:0], one strobe every 4th cycle.
    start_dl();
    for (int a = 0; a < int'(IMG); a++) begin
      tick(1'b1, 1'b1, 25'(a), 8'(a));
      if (a == int'(R1) - 1) begin
        check("r0_last_we", bus.rom_we, 4'b0001);
        check("r0_last_addr", bus.rom_addr, 17'h000FF);
      end
      if (a == int'(R1)) begin
        check("r1_first_we", bus.rom_we, 4'b0010);
        check("r1_first_addr", bus.rom_addr, 17'h0);
      end
      idle(3);
    end
    end_dl();
    check("full_load_ok", load_ok, 1);
    check("full_byte_cnt", byte_cnt, 25'h400);
    check("full_csum", csum, 8'h00);
    n = 0;
    while (core_reset && n < HOLD + 50) begin
      idle(1);
      n++;
    end
    check("hold_len", n, HOLD);

    // Reload from RUN.
    start_dl();
    check("reload_core_reset", core_reset, 1);
    check("reload_byte_cnt", byte_cnt, 0);
    seq_load(int'(IMG), 1, 1'b0);
    end_dl();
    idle(HOLD + 3);
    check("reload_run", core_reset, 0);

    // Short load.
    start_dl();
    seq_load(int'(IMG) - 1, 1, 1'b1);
    end_dl();
    check("short_err", load_err, 1);
    check("short_ok", load_ok, 0);
    idle(2000);
    check("short_held", core_reset, 1);

    // Full image plus one out-of-range write.
    start_dl();
    seq_load(int'(IMG), 0, 1'b1);
    tick(1'b1, 1'b1, IMG, 8'h55);
    check("oor_no_we", bus.rom_we, 0);
    end_dl();
    check("oor_err", load_err, 1);
    check("oor_byte_cnt", byte_cnt, 25'h400);

    // Abort a hold, then reset in the middle of the new load.
    start_dl();
    seq_load(int'(IMG), 0, 1'b0);
    end_dl();
    idle(5);
    start_dl();
    check("abort_ok", load_ok, 0);
    check("abort_core_reset", core_reset, 1);
    tick(1'b1, 1'b1, 25'h0, 8'hAA);
    check("pre_rst_we", bus.rom_we, 4'b0001);
    reset_n = 1'b0;
    #1;
    check("mid_rst_we", bus.rom_we, 0);
    check("mid_rst_core_reset", core_reset, 1);
    check("mid_rst_byte_cnt", byte_cnt, 0);
    apply_reset();
    idle(4);

    // Randomized loads: good, scattered with out-of-range, duplicates, short.
    for (int it = 0; it < 8; it++) begin
      mode = $urandom % 4;
      start_dl();
      case (mode)
        0: seq_load(int'(IMG), 2, 1'b0);
        1: begin
          cnt = $urandom_range(int'(IMG) - 2, int'(IMG) + 2);
          for (int k = 0; k < cnt; k++)
            write_byte(25'($urandom % (int'(IMG) + 4)), 8'($urandom), $urandom % 3);
        end
        2: begin
          seq_load(int'(IMG), 1, 1'b0);
          write_byte(25'($urandom % int'(IMG)), 8'($urandom), 0);
        end
        default: seq_load($urandom_range(1, int'(IMG)), 2, 1'b0);
      endcase
      end_dl();
      idle($urandom_range(0, HOLD + 10));
    end
    idle(HOLD + 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rom_load_ctrl.md
# rom_load_ctrl

Sequences the HPS ROM download stream into the game core's ROM regions and owns the core's reset during and after a load. It sits between `hps_io` (ioctl outputs) and the game core ROM-write port. It decodes the flat download address into four region write strobes with region-local addresses, and counts and checksums the stream. It validates the image size and releases the core only after a clean load plus a settle delay.

## Interface

Parameters:
- `AW`, 17: width of region-local ROM address.
- `R1_BASE`, 25'h08000: first byte of region 1. Region 0 starts at 0.
- `R2_BASE`, 25'h10000: first byte of region 2.
- `R3_BASE`, 25'h18000: first byte of region 3.
- `IMG_SIZE`, 25'h1C000: exact expected image length in bytes; also the end of region 3.
- `HOLD_CYCLES`, 16'd4096: clocks `core_reset` stays high after a good load ends (minimum 1).

Ports:
- `clk_sys`, in, 1: system clock (48 MHz).
- `reset_n`, in, 1: asynchronous, active-low reset.
- `ioctl_download`, in, 1: download window active.
- `ioctl_wr`, in, 1: one-cycle byte strobe.
- `ioctl_addr`, in, 25: flat byte address.
- `ioctl_dout`, in, 8: byte data.
- `rom_we`, out, 4: one-hot region write strobe.
- `rom_addr`, out, AW: region-local address (`ioctl_addr` minus region base, truncated).
- `rom_data`, out, 8: byte to write.
- `core_reset`, out, 1: active-high hold for game core.
- `load_ok`, out, 1: last load valid.
- `load_err`, out, 1: last load invalid.
- `byte_cnt`, out, 25: bytes accepted in current/last load.
- `csum`, out, 8: mod-256 sum of accepted bytes.

## Operation

- **States:** IDLE, LOAD, HOLD, RUN, ERR.
- **Reset (async, `reset_n`=0):** state=IDLE; `core_reset`=1; `rom_we`=0; `rom_addr`=0; `rom_data`=0; `load_ok`=0; `load_err`=0; `byte_cnt`=0; `csum`=0; hold counter=0.
- **IDLE:** the core is held. `ioctl_download`=1 goes to LOAD.
- **Entering LOAD from any state:**
  - Clears `byte_cnt`, `csum`, `load_ok`, `load_err`, and an internal `oor` flag.
  - Sets `core_reset`=1.
- **LOAD:** each `ioctl_wr` is decoded:
  - `addr < R1_BASE` → region 0.
  - `< R2_BASE` → region 1.
  - `< R3_BASE` → region 2.
  - `< IMG_SIZE` → region 3.
  - `>= IMG_SIZE` → no strobe; `oor` set.
- **Accepted (in-range) writes:** drive the selected `rom_we` bit, `rom_addr`, and `rom_data`. They also increment `byte_cnt` and add the byte to `csum`.
- **Out-of-range writes:** do not change `byte_cnt` or `csum`.
- **`ioctl_wr` while `ioctl_download`=0:** ignored in every state.
- **LOAD exit on `ioctl_download` falling:**
  - If `byte_cnt==IMG_SIZE` and `oor`=0, set `load_ok`=1 and go to HOLD with counter=HOLD_CYCLES-1.
  - Otherwise set `load_err`=1 and go to ERR.
- **HOLD:** decrements each clock. At 0 go to RUN.
- **RUN:** `core_reset`=0.
- **ERR:** `core_reset` stays 1 until the next download.
- **Duplicate addresses:** each write is counted. Resending a byte therefore causes a size error.
- `byte_cnt` saturates at 2^25-1.

## Timing

- Write path is one register stage: `ioctl_wr` at cycle N gives `rom_we`/`rom_addr`/`rom_data` valid at N+1 for exactly one cycle.
- `rom_we` is never asserted for two consecutive cycles unless `ioctl_wr` was.
- `byte_cnt` and `csum` update at N+1, together with `rom_we`.
- `ioctl_download` rising at cycle N gives state=LOAD and cleared flags at N+1. `core_reset` is already 1 there, or becomes 1 at N+1 from RUN.
- A write strobed in the same cycle as the download fall is ignored; the window is closed.
- The `ioctl_download` fall at cycle N evaluates the size at N+1, using the `byte_cnt` value from cycle N.
- Good load: `load_ok`=1 at N+1; `core_reset` falls at N+1+HOLD_CYCLES.
- Bad load: `load_err`=1 at N+1; `core_reset` stays 1.
- A download rising during HOLD aborts the hold: back to LOAD, and `load_ok` clears.
- `load_ok` and `load_err` are never both 1.
- Async reset mid-LOAD returns to IDLE immediately. Any partial write strobe is cancelled combinationally via async clear.

## Test plan

- **Reset:** pulse `reset_n` low → all outputs at their reset values, `core_reset`=1, state IDLE.
- **Full load:** stream bytes 0..IMG_SIZE-1 with data = addr[7:0], `ioctl_wr` every 4th cycle.
  - Region 0 at `addr`=25'h07FFF: `rom_we`=4'b0001, `rom_addr`=17'h07FFF.
  - Region 1 at 25'h08000: `rom_we`=4'b0010, `rom_addr`=0.
  - End state: `byte_cnt`=25'h1C000, `csum`=8'h00, `load_ok`=1.
  - `core_reset` falls exactly HOLD_CYCLES clocks after `load_ok` rises.
- **Short load:** stop at IMG_SIZE-1 bytes → `load_err`=1, `load_ok`=0, `core_reset` stays 1 for 10k cycles.
- **Out-of-range:** full image plus one write at 25'h1C000 → no `rom_we`, `byte_cnt`=25'h1C000, `load_err`=1.
- **Reload from RUN:** second download starts → `core_reset`=1 the next cycle and counters cleared. A good second load gives RUN again.
- **Hold abort and reset mid-load:**
  - Download rising during HOLD → `load_ok`=0, state LOAD.
  - `reset_n` low mid-LOAD → `rom_we`=0 within the same cycle, state IDLE.
